// File: rtl/reglk_wr_filter.sv
// Lock-enforcing register file: serves bus reads/writes to NUM_REGS protected registers,
// dropping and counting writes whose lock bit is set. Optional macro: REGLK_JTAG_BYPASS_EN.
module reglk_wr_filter #(
    parameter int          NUM_REGS  = 16,
    parameter int          LOCK_WORD = 0,
    parameter int          ADDR_W    = 5,
    parameter logic [31:0] RESET_VAL = 32'h0
) (
    input  logic                     clk_i,
    input  logic                     rst_low,
    input  logic [31:0]              reglk_i [5:0],
    input  logic                     jtag_unlock_i,
    input  logic                     req_i,
    input  logic                     we_i,
    input  logic [ADDR_W-1:0]        addr_i,
    input  logic [31:0]              wdata_i,
    output logic                     gnt_o,
    output logic                     rvalid_o,
    output logic [31:0]              rdata_o,
    output logic                     err_o,
    output logic                     viol_irq_o,
    output logic [7:0]               viol_cnt_o,
    output logic [NUM_REGS*32-1:0]   regs_o
);

    typedef enum logic [1:0] {IDLE, CHECK, RESP} state_t;

    state_t              state_reg, state_next;
    logic                req_we_reg;
    logic [ADDR_W-1:0]   req_addr_reg;
    logic [31:0]         req_wdata_reg;
    logic [31:0]         regs_reg [NUM_REGS];
    logic [31:0]         rdata_reg;
    logic                rvalid_reg;
    logic                err_reg;
    logic                irq_reg;
    logic [7:0]          cnt_reg;

    logic                is_check;
    logic                in_range;
    logic                lock_bit;
    logic                lock_eff;
    logic                blocked;
    logic                wr_en;
    logic [31:0]         rd_val;
    logic                unused_inputs;

    // Next-state and grant
    always_comb begin
        state_next = state_reg;
        gnt_o      = 1'b0;
        case (state_reg)
            IDLE: begin
                gnt_o = req_i && rst_low;
                if (req_i) state_next = CHECK;
            end
            CHECK:   state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Evaluation of the captured request; the lock is sampled live in the CHECK cycle
    always_comb begin
        is_check = (state_reg == CHECK);
        in_range = 32'(req_addr_reg) < NUM_REGS;
        lock_bit = in_range && reglk_i[LOCK_WORD][req_addr_reg];
`ifdef REGLK_JTAG_BYPASS_EN
        lock_eff = lock_bit && !jtag_unlock_i;
`else
        lock_eff = lock_bit;
`endif
        blocked  = is_check && in_range && req_we_reg && lock_eff;
        wr_en    = is_check && in_range && req_we_reg && !lock_eff;
        rd_val   = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (req_addr_reg == ADDR_W'(k)) rd_val = regs_reg[k];
        end
    end

    // Only one lock word (and, in production builds, no debug input) feeds the logic
    always_comb begin
        unused_inputs = jtag_unlock_i;
        for (int w = 0; w < 6; w++) begin
            unused_inputs = unused_inputs ^ (^reglk_i[w]);
        end
    end

    always_ff @(posedge clk_i or negedge rst_low) begin
        if (!rst_low) begin
            state_reg     <= IDLE;
            req_we_reg    <= 1'b0;
            req_addr_reg  <= '0;
            req_wdata_reg <= '0;
            rvalid_reg    <= 1'b0;
            err_reg       <= 1'b0;
            rdata_reg     <= '0;
            irq_reg       <= 1'b0;
            cnt_reg       <= '0;
        end else begin
            state_reg <= state_next;
            if (gnt_o) begin
                req_we_reg    <= we_i;
                req_addr_reg  <= addr_i;
                req_wdata_reg <= wdata_i;
            end
            // Response fields are zero outside the RESP cycle
            rvalid_reg <= is_check;
            err_reg    <= is_check && (!in_range || blocked);
            rdata_reg  <= (is_check && in_range && !req_we_reg) ? rd_val : '0;
            irq_reg    <= blocked;
            if (blocked && cnt_reg != 8'hFF) cnt_reg <= cnt_reg + 8'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_low) begin
        if (!rst_low) begin
            for (int k = 0; k < NUM_REGS; k++) regs_reg[k] <= RESET_VAL;
        end else if (wr_en) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                if (req_addr_reg == ADDR_W'(k)) regs_reg[k] <= req_wdata_reg;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_regs_out
            assign regs_o[32*gi +: 32] = regs_reg[gi];
        end
    endgenerate

    assign rvalid_o   = rvalid_reg;
    assign err_o      = err_reg;
    assign rdata_o    = rdata_reg;
    assign viol_irq_o = irq_reg;
    assign viol_cnt_o = cnt_reg;

endmodule

// File: tb/tb_reglk_wr_filter.sv
// Self-checking bench for reglk_wr_filter: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a transaction-level model.
module tb_reglk_wr_filter;

    localparam int NREG  = 16;
    localparam int LWORD = 0;

    logic            clk = 1'b0;
    logic            rst_low;
    logic [31:0]     reglk [5:0];
    logic            jtag;
    logic            req, we;
    logic [4:0]      addr;
    logic [31:0]     wdata;
    logic            gnt, rvalid, err, irq;
    logic [31:0]     rdata;
    logic [7:0]      cnt;
    logic [NREG*32-1:0] regs;

    int total = 0;
    int bad   = 0;

    reglk_wr_filter #(
        .NUM_REGS (NREG),
        .LOCK_WORD(LWORD),
        .ADDR_W   (5),
        .RESET_VAL(32'h0)
    ) dut (
        .clk_i        (clk),
        .rst_low      (rst_low),
        .reglk_i      (reglk),
        .jtag_unlock_i(jtag),
        .req_i        (req),
        .we_i         (we),
        .addr_i       (addr),
        .wdata_i      (wdata),
        .gnt_o        (gnt),
        .rvalid_o     (rvalid),
        .rdata_o      (rdata),
        .err_o        (err),
        .viol_irq_o   (irq),
        .viol_cnt_o   (cnt),
        .regs_o       (regs)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40) $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model, checked every cycle ----------------
    logic [31:0] m_regs [NREG];
    int          m_cnt   = 0;
    int          cyc     = 0;
    int          t_grant = -100;
    logic        m_we;
    int          m_addr;
    logic [31:0] m_wdata;
    logic [31:0] r_rdata;
    logic        r_err, r_irq;

    always @(negedge clk) begin
        logic exp_gnt, exp_rv, lk;
        cyc++;
        if (rst_low !== 1'b1) begin
            for (int k = 0; k < NREG; k++) m_regs[k] = 32'h0;
            m_cnt   = 0;
            t_grant = -100;
            chk("rst_gnt", {31'b0, gnt}, 32'h0);
            chk("rst_rvalid", {31'b0, rvalid}, 32'h0);
            chk("rst_err", {31'b0, err}, 32'h0);
            chk("rst_irq", {31'b0, irq}, 32'h0);
            chk("rst_rdata", rdata, 32'h0);
            chk("rst_cnt", {24'b0, cnt}, 32'h0);
            for (int k = 0; k < NREG; k++) chk($sformatf("rst_reg%0d", k), regs[32*k +: 32], 32'h0);
        end else begin
            exp_gnt = req && (cyc - t_grant >= 3);
            exp_rv  = (cyc == t_grant + 2);
            chk("gnt", {31'b0, gnt}, {31'b0, exp_gnt});
            chk("rvalid", {31'b0, rvalid}, {31'b0, exp_rv});
            chk("rdata", rdata, exp_rv ? r_rdata : 32'h0);
            chk("err", {31'b0, err}, {31'b0, exp_rv && r_err});
            chk("irq", {31'b0, irq}, {31'b0, exp_rv && r_irq});
            chk("cnt", {24'b0, cnt}, 32'(m_cnt));
            for (int k = 0; k < NREG; k++) chk($sformatf("reg%0d", k), regs[32*k +: 32], m_regs[k]);
            if (exp_gnt) begin
                t_grant = cyc;
                m_we    = we;
                m_addr  = int'(addr);
                m_wdata = wdata;
            end else if (cyc == t_grant + 1) begin
                r_rdata = 32'h0;
                r_err   = 1'b0;
                r_irq   = 1'b0;
                if (m_addr >= NREG) begin
                    r_err = 1'b1;
                end else if (!m_we) begin
                    r_rdata = m_regs[m_addr];
                end else begin
                    lk = reglk[LWORD][m_addr];
`ifdef REGLK_JTAG_BYPASS_EN
                    if (jtag) lk = 1'b0;
`endif
                    if (lk) begin
                        r_err = 1'b1;
                        r_irq = 1'b1;
                        if (m_cnt < 255) m_cnt++;
                    end else begin
                        m_regs[m_addr] = m_wdata;
                    end
                end
            end
        end
    end

    // ---------------- directed transaction driver ----------------
    logic [31:0] resp_rdata;
    logic        resp_err, resp_irq;
    logic [7:0]  resp_cnt;
    int          resp_lat;

    task automatic txn(input logic w, input logic [4:0] a, input logic [31:0] d,
                       input logic chg, input logic [31:0] lock_after);
        int   n;
        logic got;
        @(posedge clk); #1;
        req = 1'b1; we = w; addr = a; wdata = d;
        got = 1'b0; n = 0;
        while (!got && n < 6) begin
            @(negedge clk);
            got = gnt;
            n++;
        end
        if (!got) begin
            chk("grant_timeout", 32'h0, 32'h1);
            req = 1'b0;
            resp_lat = -1;
            return;
        end
        @(posedge clk); #1;
        req = 1'b0; we = 1'($urandom); addr = 5'($urandom); wdata = $urandom;
        if (chg) reglk[LWORD] = lock_after;
        got = 1'b0; n = 0;
        while (!got && n < 6) begin
            @(negedge clk);
            n++;
            if (rvalid) begin
                got = 1'b1;
                resp_rdata = rdata; resp_err = err; resp_irq = irq; resp_cnt = cnt;
            end
        end
        resp_lat = got ? n : -1;
        if (!got) chk("rvalid_timeout", 32'h0, 32'h1);
        $display("txn we=%0b addr=%0d wdata=%h -> rdata=%h err=%0b irq=%0b cnt=%0d lat=%0d",
                 w, a, d, resp_rdata, resp_err, resp_irq, resp_cnt, resp_lat);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_low = 1'b0; jtag = 1'b0; req = 1'b1; we = 1'b0; addr = '0; wdata = '0;
        for (int w = 0; w < 6; w++) reglk[w] = 32'h0;
        repeat (3) @(negedge clk);
        chk("gnt_in_reset", {31'b0, gnt}, 32'h0);
        @(posedge clk); #1;
        req = 1'b0; rst_low = 1'b1;

        // reads after reset
        for (int a = 0; a < NREG; a++) begin
            txn(1'b0, 5'(a), 32'h0, 1'b0, 32'h0);
            chk("rd_reset_data", resp_rdata, 32'h0);
            chk("rd_reset_err", {31'b0, resp_err}, 32'h0);
            chk("rd_latency", 32'(resp_lat), 32'd2);
        end

        // unlocked write then read-back
        txn(1'b1, 5'd3, 32'hDEADBEEF, 1'b0, 32'h0);
        chk("wr3_err", {31'b0, resp_err}, 32'h0);
        txn(1'b0, 5'd3, 32'h0, 1'b0, 32'h0);
        chk("rd3_data", resp_rdata, 32'hDEADBEEF);
        @(negedge clk);
        chk("regs_o_3", regs[127:96], 32'hDEADBEEF);

        // locked write is dropped and counted
        reglk[0] = 32'h0000_0008;
        txn(1'b1, 5'd3, 32'h12345678, 1'b0, 32'h0);
        chk("lk_err", {31'b0, resp_err}, 32'h1);
        chk("lk_irq", {31'b0, resp_irq}, 32'h1);
        chk("lk_cnt", {24'b0, resp_cnt}, 32'h1);
        @(negedge clk);
        chk("lk_irq_pulse", {31'b0, irq}, 32'h0);
        chk("lk_reg3", regs[127:96], 32'hDEADBEEF);
        txn(1'b0, 5'd3, 32'h0, 1'b0, 32'h0);
        chk("lk_read_ok", resp_rdata, 32'hDEADBEEF);

        // lock rising after grant blocks; lock falling after grant permits
        reglk[0] = 32'h0;
        txn(1'b1, 5'd5, 32'hCAFEF00D, 1'b1, 32'h0000_0020);
        chk("rise_err", {31'b0, resp_err}, 32'h1);
        chk("rise_cnt", {24'b0, resp_cnt}, 32'h2);
        txn(1'b1, 5'd5, 32'h0BADF00D, 1'b1, 32'h0);
        chk("fall_err", {31'b0, resp_err}, 32'h0);
        txn(1'b0, 5'd5, 32'h0, 1'b0, 32'h0);
        chk("fall_data", resp_rdata, 32'h0BADF00D);

        // out-of-range address
        reglk[0] = 32'hFFFF_FFFF;
        txn(1'b1, 5'd20, 32'h55555555, 1'b0, 32'h0);
        chk("oor_wr_err", {31'b0, resp_err}, 32'h1);
        chk("oor_wr_irq", {31'b0, resp_irq}, 32'h0);
        chk("oor_cnt", {24'b0, resp_cnt}, 32'h2);
        txn(1'b0, 5'd20, 32'h0, 1'b0, 32'h0);
        chk("oor_rd_err", {31'b0, resp_err}, 32'h1);
        chk("oor_rd_data", resp_rdata, 32'h0);

        // saturation of the violation counter
        for (int i = 0; i < 300; i++) txn(1'b1, 5'($urandom_range(0, 15)), $urandom, 1'b0, 32'h0);
        chk("sat_cnt", {24'b0, resp_cnt}, 32'hFF);
        chk("sat_reg3", regs[127:96], 32'hDEADBEEF);

        // reset during CHECK discards the request
        reglk[0] = 32'h0;
        @(posedge clk); #1;
        req = 1'b1; we = 1'b1; addr = 5'd2; wdata = 32'h11112222;
        @(negedge clk);
        chk("mid_gnt", {31'b0, gnt}, 32'h1);
        @(posedge clk); #1;
        req = 1'b0; rst_low = 1'b0;
        @(negedge clk);
        chk("mid_rvalid", {31'b0, rvalid}, 32'h0);
        chk("mid_cnt", {24'b0, cnt}, 32'h0);
        chk("mid_reg3", regs[127:96], 32'h0);
        @(posedge clk); #1;
        rst_low = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mid_no_resp", {31'b0, rvalid}, 32'h0);
            chk("mid_reg2", regs[95:64], 32'h0);
        end

        // debug unlock
        reglk[0] = 32'h0000_0002;
        jtag = 1'b1;
        txn(1'b1, 5'd1, 32'hA5A5A5A5, 1'b0, 32'h0);
        jtag = 1'b0;
`ifdef REGLK_JTAG_BYPASS_EN
        chk("jtag_err", {31'b0, resp_err}, 32'h0);
        chk("jtag_cnt", {24'b0, resp_cnt}, 32'h0);
        txn(1'b0, 5'd1, 32'h0, 1'b0, 32'h0);
        chk("jtag_reg1", resp_rdata, 32'hA5A5A5A5);
`else
        chk("jtag_err", {31'b0, resp_err}, 32'h1);
        chk("jtag_cnt", {24'b0, resp_cnt}, 32'h1);
        txn(1'b0, 5'd1, 32'h0, 1'b0, 32'h0);
        chk("jtag_reg1", resp_rdata, 32'h0);
`endif

        // randomized traffic, lock churn and occasional resets
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            rst_low = ($urandom_range(0, 149) != 0);
            req     = ($urandom_range(0, 2) != 0);
            we      = 1'($urandom);
            addr    = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(16, 31)) : 5'($urandom_range(0, 15));
            wdata   = $urandom;
            jtag    = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 3) == 0) reglk[LWORD] = $urandom & $urandom;
            for (int w = 1; w < 6; w++) reglk[w] = $urandom;
        end
        @(posedge clk); #1;
        rst_low = 1'b1; req = 1'b0;
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
